iir_cascade_filter: RTL and testbench
=====================================

Name: iir_cascade_filter

Overview:
Parametrised successor of the fixed first-order lowpass/highpass sample filter. It is a cascade of up to STAGES first-order exponential IIR sections sharing one multiply-shift datapath, with stages evaluated sequentially. It has generic data width, generalised odd-numerator weights, runtime-selectable cascade depth and a valid/ready sample handshake. It sits between the sample input pins and the output/display logic of the top level.

Parameters:
DATA_W, 8, sample width (unsigned input and output)
FRAC_W, 4, extra fractional bits held in each stage accumulator
WG_W, 2, weight-select width; alpha = (2*wg+1)/2^(WG_W+1)
STAGES, 4, maximum number of cascaded sections (1..16)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  input sample valid
in_data  in  DATA_W  unsigned input sample
in_ready  out  1  block can accept a sample this cycle
cfg_en  in  1  configuration strobe
cfg_hp  in  1  0 = lowpass, 1 = highpass
cfg_wg  in  WG_W  weight select
cfg_stages  in  $clog2(STAGES+1)  active cascade depth
out_valid  out  1  one-cycle pulse, out_data valid
out_data  out  DATA_W  filtered sample
overrun  out  1  one-cycle pulse, sample dropped

Behaviour:
- Interface decision: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset, asynchronous at any time including mid-computation: FSM to IDLE, all accumulators 0, config = LP / wg 0 / 1 stage, pending config cleared, out_data 0, out_valid 0, overrun 0. After reset, in_ready = 1.
- FSM:
  - IDLE: in_ready = 1. When in_valid = 1, latch in_data, stage index k = 0, go to RUN.
  - RUN: in_ready = 0. One stage per cycle. After stage N-1 (N = active depth), go to EMIT.
  - EMIT: in_ready = 0. Register out_data, out_valid = 1 for this cycle only. Go to IDLE.
- Latency: a sample accepted at clock edge e0 gives out_valid high in the cycle after edge e0+N. in_ready is low for N+1 cycles, so one sample is accepted per N+2 cycles.
- Stage arithmetic, with signed internal width W = DATA_W+FRAC_W+2:
  - Stage 0 input u = in_data << FRAC_W. Stage k>0 input = acc[k-1] after its update in the same sample.
  - d = u - acc[k]; acc[k] += (d*(2*wg+1)) >>> (WG_W+1), using an arithmetic shift (floor).
- Output:
  - lp = (acc[N-1] + 2^(FRAC_W-1)) >> FRAC_W, saturated to 0..2^DATA_W-1.
  - LP mode: out_data = lp.
  - HP mode: out_data = sat(in_data - lp + 2^(DATA_W-1)), i.e. offset-binary with mid-scale at zero.
- Accumulators of stages >= N are held and not updated.
- in_valid while in_ready = 0: sample is dropped, overrun pulses 1 cycle, and the computation in flight is unaffected.
- Configuration:
  - cfg_en in IDLE: applied at the next edge.
  - cfg_en in RUN or EMIT: captured into a pending register (last strobe wins) and applied on the EMIT->IDLE transition.
  - Applying a config clears all accumulators to 0.
  - cfg_stages = 0 is treated as 1; values > STAGES are clamped to STAGES.
  - cfg_en together with in_valid in IDLE: the config is applied first and the sample is accepted with the new config, with cleared accumulators.
- out_data holds its value between out_valid pulses.

Test Plan:
1. Reset check. Assert rst mid-RUN (N = 4, 2 cycles in) -> out_valid = 0, out_data = 0 immediately. After release: in_ready = 1 and the next sample uses LP/wg 0/1 stage.
2. LP step, 1 stage. Config LP, wg = 3 (alpha 7/8), stages 1; feed 255, 255 -> acc 3570 then 4016; out_data 223 then 251, each out_valid exactly 2 cycles after acceptance.
3. HP, 1 stage. Config HP, wg = 0 (alpha 1/8); feed 64 -> acc 128, lp 8, out_data 184. Feed 255 from a fresh config -> lp 32, raw 351 -> saturates to 255.
4. Latency and depth. Stages 4: accept at edge t -> out_valid at t+5, in_ready low 5 cycles. Stages 0 behaves as 1; stages 7 behaves as 4 (5-cycle in_ready gap).
5. Overrun. Hold in_valid high continuously with N = 2 -> exactly one sample accepted per 4 cycles; overrun pulses on each busy cycle; out_data sequence matches a model fed only the accepted samples.
6. Pending config. Issue cfg_en (HP, wg 2) during RUN -> current output still LP-based. Next sample sees cleared accumulators: with 64 and alpha 5/8, acc 640, lp 40, out_data 152.

Source files
------------

// File: rtl/iir_cascade_filter.sv
// Cascade of first-order exponential IIR sections. All sections share one multiply-shift
// datapath and are evaluated one per cycle, with a valid/ready sample handshake.
module iir_cascade_filter #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 4,
  parameter int WG_W   = 2,
  parameter int STAGES = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [DATA_W-1:0]                in_data,
  output logic                             in_ready,
  input  logic                             cfg_en,
  input  logic                             cfg_hp,
  input  logic [WG_W-1:0]                  cfg_wg,
  input  logic [$clog2(STAGES+1)-1:0]      cfg_stages,
  output logic                             out_valid,
  output logic [DATA_W-1:0]                out_data,
  output logic                             overrun
);
  localparam int W     = DATA_W + FRAC_W + 2;
  localparam int P_W   = W + WG_W + 2;
  localparam int CS_W  = $clog2(STAGES + 1);
  localparam int IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic signed [W-1:0] ZERO_S = {W{1'b0}};
  localparam logic signed [W-1:0] MAX_S  = W'((1 << DATA_W) - 1);
  localparam logic signed [W-1:0] RND_S  = W'(1 << (FRAC_W - 1));
  localparam logic signed [W-1:0] HALF_S = W'(1 << (DATA_W - 1));

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, EMIT = 2'd2} state_t;

  state_t                   state_r, state_s;
  logic [DATA_W-1:0]        sample_r;
  logic [IDX_W-1:0]         k_r;
  logic signed [W-1:0]      acc_r [STAGES];
  logic                     hp_r, pend_hp_r, pend_valid_r;
  logic [WG_W-1:0]          wg_r, pend_wg_r;
  logic [CS_W-1:0]          n_r, pend_n_r;
  logic [DATA_W-1:0]        out_data_r;
  logic                     out_valid_r, overrun_r;

  logic signed [W-1:0]      u_s, acc_cur_s, d_s, acc_new_s, rnd_s, samp_ext_s, lp_ext_s;
  logic signed [P_W-1:0]    prod_s, mul_s;
  logic [DATA_W-1:0]        lp_s, hp_s, out_next_s;
  logic                     last_s;

  function automatic logic [CS_W-1:0] clamp_stages(input logic [CS_W-1:0] s);
    logic [CS_W-1:0] r;
    if (s == {CS_W{1'b0}}) r = CS_W'(1);
    else if (s > CS_W'(STAGES)) r = CS_W'(STAGES);
    else r = s;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] sat_u(input logic signed [W-1:0] v);
    logic [DATA_W-1:0] r;
    if (v < ZERO_S) r = {DATA_W{1'b0}};
    else if (v > MAX_S) r = {DATA_W{1'b1}};
    else r = v[DATA_W-1:0];
    return r;
  endfunction

  assign in_ready  = (state_r == IDLE);
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign overrun   = overrun_r;

  // Shared section datapath plus output formatting from the section being updated
  always_comb begin
    u_s = ZERO_S;
    if (k_r == {IDX_W{1'b0}}) u_s = W'({sample_r, {FRAC_W{1'b0}}});
    else u_s = acc_r[k_r - IDX_W'(1)];
    acc_cur_s  = acc_r[k_r];
    d_s        = u_s - acc_cur_s;
    mul_s      = P_W'({1'b0, wg_r, 1'b1});
    prod_s     = P_W'(d_s) * mul_s;
    acc_new_s  = acc_cur_s + W'(prod_s >>> (WG_W + 1));
    rnd_s      = (acc_new_s + RND_S) >>> FRAC_W;
    lp_s       = sat_u(rnd_s);
    samp_ext_s = W'(sample_r);
    lp_ext_s   = W'(lp_s);
    hp_s       = sat_u(samp_ext_s - lp_ext_s + HALF_S);
    if (hp_r) out_next_s = hp_s;
    else out_next_s = lp_s;
    last_s     = (CS_W'(k_r) == (n_r - CS_W'(1)));
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_s = RUN;
        else state_s = IDLE;
      end
      RUN: begin
        if (last_s) state_s = EMIT;
        else state_s = RUN;
      end
      EMIT:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, accumulators, configuration and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      sample_r     <= {DATA_W{1'b0}};
      k_r          <= {IDX_W{1'b0}};
      for (int i = 0; i < STAGES; i++) acc_r[i] <= ZERO_S;
      hp_r         <= 1'b0;
      wg_r         <= {WG_W{1'b0}};
      n_r          <= CS_W'(1);
      pend_valid_r <= 1'b0;
      pend_hp_r    <= 1'b0;
      pend_wg_r    <= {WG_W{1'b0}};
      pend_n_r     <= CS_W'(1);
      out_data_r   <= {DATA_W{1'b0}};
      out_valid_r  <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      out_valid_r <= 1'b0;
      overrun_r   <= in_valid && (state_r != IDLE);
      case (state_r)
        IDLE: begin
          // Config goes in before a coincident sample so the sample sees it.
          if (cfg_en) begin
            hp_r <= cfg_hp;
            wg_r <= cfg_wg;
            n_r  <= clamp_stages(cfg_stages);
            for (int i = 0; i < STAGES; i++) acc_r[i] <= ZERO_S;
          end
          if (in_valid) begin
            sample_r <= in_data;
            k_r      <= {IDX_W{1'b0}};
          end
        end
        RUN: begin
          acc_r[k_r] <= acc_new_s;
          k_r        <= k_r + IDX_W'(1);
          if (last_s) begin
            out_data_r  <= out_next_s;
            out_valid_r <= 1'b1;
          end
          if (cfg_en) begin
            pend_valid_r <= 1'b1;
            pend_hp_r    <= cfg_hp;
            pend_wg_r    <= cfg_wg;
            pend_n_r     <= clamp_stages(cfg_stages);
          end
        end
        EMIT: begin
          pend_valid_r <= 1'b0;
          if (cfg_en) begin
            hp_r <= cfg_hp;
            wg_r <= cfg_wg;
            n_r  <= clamp_stages(cfg_stages);
            for (int i = 0; i < STAGES; i++) acc_r[i] <= ZERO_S;
          end else if (pend_valid_r) begin
            hp_r <= pend_hp_r;
            wg_r <= pend_wg_r;
            n_r  <= pend_n_r;
            for (int i = 0; i < STAGES; i++) acc_r[i] <= ZERO_S;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iir_cascade_filter.sv
// Randomized bench for iir_cascade_filter, checked against an integer reference model
// of the cascaded exponential sections.
module tb_iir_cascade_filter;
  localparam int DATA_W = 8;
  localparam int FRAC_W = 4;
  localparam int WG_W   = 2;
  localparam int STAGES = 4;
  localparam int CS_W   = $clog2(STAGES + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              cfg_en;
  logic              cfg_hp;
  logic [WG_W-1:0]   cfg_wg;
  logic [CS_W-1:0]   cfg_stages;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              overrun;

  int vectors = 0;
  int errors  = 0;

  int m_acc [STAGES];
  int m_hp, m_wg, m_n;

  iir_cascade_filter #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .WG_W(WG_W), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cfg_en(cfg_en), .cfg_hp(cfg_hp), .cfg_wg(cfg_wg), .cfg_stages(cfg_stages),
    .out_valid(out_valid), .out_data(out_data), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int floor_div(int a, int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic int clampv(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic void m_cfg(int hp, int wg, int st);
    m_hp = hp;
    m_wg = wg;
    m_n  = clampv(st, 1, STAGES);
    for (int i = 0; i < STAGES; i++) m_acc[i] = 0;
  endfunction

  function automatic int m_run(int x);
    int u, lp;
    u = x * (2 ** FRAC_W);
    for (int k = 0; k < m_n; k++) begin
      m_acc[k] = m_acc[k] + floor_div((u - m_acc[k]) * (2 * m_wg + 1), 2 ** (WG_W + 1));
      u = m_acc[k];
    end
    lp = clampv(floor_div(m_acc[m_n-1] + 2 ** (FRAC_W - 1), 2 ** FRAC_W), 0, 2 ** DATA_W - 1);
    if (m_hp != 0) return clampv(x - lp + 2 ** (DATA_W - 1), 0, 2 ** DATA_W - 1);
    return lp;
  endfunction

  task automatic wait_ready();
    for (int j = 0; j < 40 && !in_ready; j++) tick();
    check_val("ready_wait", 32'(in_ready), 32'd1);
  endtask

  task automatic apply_cfg(input int hp, input int wg, input int st);
    wait_ready();
    cfg_en = 1'b1; cfg_hp = hp[0]; cfg_wg = WG_W'(wg); cfg_stages = CS_W'(st);
    tick();
    cfg_en = 1'b0;
    m_cfg(hp, wg, st);
  endtask

  // mode 0: plain sample; 1: config with the sample; 2: config strobed mid-run
  task automatic send(input int x, input int mode, input int hp, input int wg, input int st,
                      output int res);
    int exp, t_ov, t_rdy, ov_cnt, n_used;
    logic [DATA_W-1:0] got;
    wait_ready();
    in_valid = 1'b1; in_data = DATA_W'(x);
    if (mode != 0) begin cfg_hp = hp[0]; cfg_wg = WG_W'(wg); cfg_stages = CS_W'(st); end
    cfg_en = (mode == 1);
    if (mode == 1) m_cfg(hp, wg, st);
    n_used = m_n;
    exp = m_run(x);
    tick();
    in_valid = 1'b0; cfg_en = 1'b0;
    t_ov = -1; t_rdy = -1; ov_cnt = 0; got = '0;
    for (int j = 0; j < 40; j++) begin
      if (out_valid) begin
        ov_cnt++;
        if (t_ov < 0) begin t_ov = j; got = out_data; end
      end
      if (in_ready && t_rdy < 0) t_rdy = j;
      if (t_rdy >= 0 && t_ov >= 0 && j > t_rdy) break;
      cfg_en = (mode == 2 && j == 1);
      tick();
      cfg_en = 1'b0;
    end
    check_val("latency", 32'(t_ov), 32'(n_used));
    check_val("ready_gap", 32'(t_rdy), 32'(n_used + 1));
    check_val("valid_pulses", 32'(ov_cnt), 32'd1);
    check_val("out_data", 32'(got), 32'(exp));
    check_val("out_hold", 32'(out_data), 32'(exp));
    if (mode == 2) m_cfg(hp, wg, st);
    res = int'(got);
  endtask

  initial begin
    int r, q[$], exp_o;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; cfg_en = 1'b0;
    cfg_hp = 1'b0; cfg_wg = '0; cfg_stages = '0;
    tick(); tick();
    check_val("rst_ready", 32'(in_ready), 32'd1);
    check_val("rst_valid", 32'(out_valid), 32'd0);
    check_val("rst_data", 32'(out_data), 32'd0);
    check_val("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    m_cfg(0, 0, 1);

    // Reset mid-computation with a nonzero output on the pins
    apply_cfg(0, 1, 4);
    send(200, 0, 0, 0, 0, r);
    in_valid = 1'b1; in_data = 8'd90;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #2;
    check_val("midrun_rst_valid", 32'(out_valid), 32'd0);
    check_val("midrun_rst_data", 32'(out_data), 32'd0);
    tick();
    rst = 1'b0;
    check_val("post_rst_ready", 32'(in_ready), 32'd1);
    m_cfg(0, 0, 1);
    send(255, 0, 0, 0, 0, r);
    check_val("post_rst_lp", 32'(r), 32'd32);

    // LP step, alpha 7/8
    apply_cfg(0, 3, 1);
    send(255, 0, 0, 0, 0, r); check_val("lp_step1", 32'(r), 32'd223);
    send(255, 0, 0, 0, 0, r); check_val("lp_step2", 32'(r), 32'd251);

    // HP, alpha 1/8, including saturation
    apply_cfg(1, 0, 1);
    send(64, 0, 0, 0, 0, r);  check_val("hp_64", 32'(r), 32'd184);
    apply_cfg(1, 0, 1);
    send(255, 0, 0, 0, 0, r); check_val("hp_sat", 32'(r), 32'd255);

    // Depth clamping
    apply_cfg(0, 1, 4); send($urandom_range(255), 0, 0, 0, 0, r);
    apply_cfg(0, 1, 0); send($urandom_range(255), 0, 0, 0, 0, r);
    apply_cfg(0, 1, 7); send($urandom_range(255), 0, 0, 0, 0, r);

    // Pending config captured mid-run, then cleared accumulators with new config
    apply_cfg(0, 0, 2);
    send(100, 2, 1, 2, 1, r);
    send(64, 0, 0, 0, 0, r);  check_val("pend_hp", 32'(r), 32'd152);

    // Randomized configs and samples, some with config coincident with the sample
    for (int i = 0; i < 12; i++) begin
      apply_cfg($urandom_range(1), $urandom_range(3), $urandom_range(7));
      for (int s = 0; s < 4; s++) begin
        if ($urandom_range(3) == 0)
          send($urandom_range(255), 1, $urandom_range(1), $urandom_range(3), $urandom_range(7), r);
        else
          send($urandom_range(255), 0, 0, 0, 0, r);
      end
    end

    // Continuous in_valid with depth 2: one accept per 4 cycles, overrun on busy cycles
    apply_cfg(0, 2, 2);
    for (int j = 0; j < 40; j++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'($urandom_range(255));
      check_val("ovr_ready", 32'(in_ready), 32'((j % 4) == 0));
      if ((j % 4) == 0) q.push_back(m_run(int'(in_data)));
      tick();
      check_val("ovr_pulse", 32'(overrun), 32'((j % 4) != 0));
      check_val("ovr_valid", 32'(out_valid), 32'((j % 4) == 2));
      if ((j % 4) == 2 && q.size() > 0) begin
        exp_o = q.pop_front();
        check_val("ovr_data", 32'(out_data), 32'(exp_o));
      end
    end
    in_valid = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
